lcg_stim_gen: RTL and testbench



---
 rtl/lcg_stim_pkg.sv | 32 +++
 rtl/lcg_stim_gen_if.sv | 35 +++
 rtl/lcg_stim_gen_step.sv | 15 +
 rtl/lcg_stim_gen.sv | 144 ++++++++++++++
 tb/tb_lcg_stim_gen.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcg_stim_pkg.sv
// -----------------------------------------------------------------------------
// lcg_stim_pkg
// Shared definitions for the LCG stimulus generator:
//   LCG_MUL / LCG_INC : constants of the 32-bit linear congruential generator
//   lcg_next()        : one LCG step, truncated to 32 bits
//   chunks_for()      : number of 32-bit draws needed to fill a vector
//   lcg_fsm_e         : generator control states
// Optional feature macro used by the generator: LCG_STIM_PAUSE_EN.
// -----------------------------------------------------------------------------
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h3039;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } lcg_fsm_e;

    // The product is evaluated in a 32-bit context, so the wrap modulo 2^32
    // falls out of the arithmetic with no explicit truncation.
    function automatic logic [31:0] lcg_next(input logic [31:0] state);
        return state * LCG_MUL + LCG_INC;
    endfunction

    function automatic int chunks_for(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/lcg_stim_gen_if.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen_if
// Control and stream bundle for lcg_stim_gen.
//   start, seed, num_vectors : run control, sampled on an accepted start
//   vec, vec_valid, vec_ready: generated vector with valid/ready handshake
//   vec_idx                  : 0-based index of the vector being presented
//   busy, done               : run status
// Modports:
//   master : the generator (drives vec/vec_valid/vec_idx/busy/done)
//   slave  : the controller/consumer side (drives start/seed/num/vec_ready)
// -----------------------------------------------------------------------------
interface lcg_stim_gen_if #(
    parameter int IN_W  = 138,
    parameter int CNT_W = 32
);
    logic             start;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_vectors;
    logic [IN_W-1:0]  vec;
    logic             vec_valid;
    logic             vec_ready;
    logic [CNT_W-1:0] vec_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, seed, num_vectors, vec_ready,
        output vec, vec_valid, vec_idx, busy, done
    );

    modport slave (
        output start, seed, num_vectors, vec_ready,
        input  vec, vec_valid, vec_idx, busy, done
    );
endinterface

// File: rtl/lcg_stim_gen_step.sv
// -----------------------------------------------------------------------------
// lcg_step
// Combinational single LCG step built on the package function, so every user
// of the generator arithmetic shares one definition.
//   state_i : current 32-bit LCG state
//   state_o : next 32-bit LCG state
// -----------------------------------------------------------------------------
module lcg_step
    import lcg_stim_pkg::*;
(
    input  logic [31:0] state_i,
    output logic [31:0] state_o
);
    assign state_o = lcg_next(state_i);
endmodule

// File: rtl/lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen
// Builds IN_W-bit stimulus vectors from successive 32-bit LCG draws and
// presents them on a valid/ready handshake.
// Ports:
//   clk   : sole clock, rising edge
//   rst   : asynchronous, active-high reset
//   pause : (only with LCG_STIM_PAUSE_EN defined) freezes filling and hides
//           vec_valid while high
//   bus   : lcg_stim_gen_if.master (start/seed/num_vectors in,
//           vec/vec_valid/vec_idx/busy/done out, vec_ready in)
// Configuration macro: LCG_STIM_PAUSE_EN adds the pause input; when it is
// undefined the generator never pauses.
// -----------------------------------------------------------------------------
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int IN_W  = 138,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
`ifdef LCG_STIM_PAUSE_EN
    input  logic           pause,
`endif
    lcg_stim_gen_if.master bus
);

    localparam int CHUNKS      = chunks_for(IN_W);
    localparam int CHUNK_CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CHUNK_CNT_W-1:0] LAST_CHUNK = CHUNK_CNT_W'(CHUNKS - 1);

    lcg_fsm_e               fsm_q,       fsm_d;
    logic [31:0]            lcg_q,       lcg_d;
    logic [CHUNK_CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [CNT_W-1:0]       vec_idx_q,   vec_idx_d;
    logic [IN_W-1:0]        vec_q,       vec_d;

    logic [31:0] step_out;
    logic        chunk_we;
    logic        pause_active;
    logic        handshake;

`ifdef LCG_STIM_PAUSE_EN
    assign pause_active = pause;
`else
    assign pause_active = 1'b0;
`endif

    lcg_step u_step (
        .state_i (lcg_q),
        .state_o (step_out)
    );

    // A paused VALID hides vec_valid, which also blocks the handshake.
    assign handshake = (fsm_q == VALID) && !pause_active && bus.vec_ready;

    // Each chunk slice is rewritten only on the FILL cycle that targets it;
    // the last chunk keeps just the low bits of the draw when IN_W is not a
    // multiple of 32.
    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            localparam int LO = gi * 32;
            localparam int W  = ((IN_W - LO) < 32) ? (IN_W - LO) : 32;
            assign vec_d[LO +: W] =
                (chunk_we && (chunk_cnt_q == CHUNK_CNT_W'(gi))) ? step_out[W-1:0]
                                                                : vec_q[LO +: W];
        end
    endgenerate

    always_comb begin
        fsm_d       = fsm_q;
        lcg_d       = lcg_q;
        chunk_cnt_d = chunk_cnt_q;
        remaining_d = remaining_q;
        vec_idx_d   = vec_idx_q;
        chunk_we    = 1'b0;

        case (fsm_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    lcg_d       = bus.seed;
                    remaining_d = bus.num_vectors;
                    vec_idx_d   = '0;
                    chunk_cnt_d = '0;
                    fsm_d       = (bus.num_vectors == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (!pause_active) begin
                    lcg_d    = step_out;
                    chunk_we = 1'b1;
                    if (chunk_cnt_q == LAST_CHUNK) begin
                        chunk_cnt_d = '0;
                        fsm_d       = VALID;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + CHUNK_CNT_W'(1);
                    end
                end
            end
            VALID: begin
                if (handshake) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        // Last vector: index stays on the final value.
                        fsm_d = DONE;
                    end else begin
                        vec_idx_d   = vec_idx_q + CNT_W'(1);
                        chunk_cnt_d = '0;
                        fsm_d       = FILL;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            lcg_q       <= '0;
            chunk_cnt_q <= '0;
            remaining_q <= '0;
            vec_idx_q   <= '0;
            vec_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            lcg_q       <= lcg_d;
            chunk_cnt_q <= chunk_cnt_d;
            remaining_q <= remaining_d;
            vec_idx_q   <= vec_idx_d;
            vec_q       <= vec_d;
        end
    end

    assign bus.vec       = vec_q;
    assign bus.vec_valid = (fsm_q == VALID) && !pause_active;
    assign bus.vec_idx   = vec_idx_q;
    assign bus.busy      = (fsm_q == FILL) || (fsm_q == VALID);
    assign bus.done      = (fsm_q == DONE);

endmodule

// File: tb/tb_lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_lcg_stim_gen
// Self-checking bench for lcg_stim_gen: a table of whole runs checked against
// an independent LCG model, plus directed sequences for back-pressure, ignored
// start, reset mid-fill and (with LCG_STIM_PAUSE_EN) pausing.
// -----------------------------------------------------------------------------
module tb_lcg_stim_gen;

    localparam int IN_W   = 138;
    localparam int CNT_W  = 32;
    localparam int CHUNKS = 5;
    localparam int LAT    = CHUNKS + 1;

    logic clk = 1'b0;
    logic rst;
`ifdef LCG_STIM_PAUSE_EN
    logic pause;
`endif

    always #5 clk = ~clk;

    lcg_stim_gen_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus_if ();

    lcg_stim_gen #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef LCG_STIM_PAUSE_EN
        .pause (pause),
`endif
        .bus   (bus_if)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] seed;
        int          num;
        bit          has_hand;
        logic [63:0] hand_lo64;
    } row_t;

    row_t rows[4];

    // Independent model: 64-bit product, keep the low word.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [63:0] p;
        p = {32'b0, s} * 64'h0000_0000_41C6_4E6D + 64'h3039;
        return p[31:0];
    endfunction

    task automatic m_vec(inout logic [31:0] s, output logic [IN_W-1:0] v);
        logic [CHUNKS*32-1:0] w;
        w = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            s = m_step(s);
            w[k*32 +: 32] = s;
        end
        v = w[IN_W-1:0];
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] seed, input int num);
        bus_if.seed        = seed;
        bus_if.num_vectors = CNT_W'(num);
        bus_if.start       = 1'b1;
        tick();
        bus_if.start       = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            cycles++;
            if (bus_if.vec_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_stream(input row_t r);
        logic [31:0]     s;
        logic [IN_W-1:0] ev;
        int              c;
        bit              ok;
        s = r.seed;
        bus_if.vec_ready = 1'b1;
        do_start(r.seed, r.num);
        if (r.num == 0) begin
            check("zero_done", bus_if.done, 1'b1);
            check("zero_busy", bus_if.busy, 1'b0);
            ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (bus_if.vec_valid !== 1'b0) ok = 1'b1;
                tick();
            end
            check("zero_no_valid", ok, 1'b0);
            $display("run seed=%h num=0 finished", r.seed);
            return;
        end
        for (int v = 0; v < r.num; v++) begin
            wait_valid(c, ok);
            check("valid_timeout", ok, 1'b1);
            if (!ok) return;
            check("latency", c, (v == 0) ? LAT - 1 : LAT);
            m_vec(s, ev);
            check("vec", bus_if.vec, ev);
            check("vec_idx", bus_if.vec_idx, v);
            check("done_low", bus_if.done, 1'b0);
            if (v == 0 && r.has_hand)
                check("vec_lo64_hand", bus_if.vec[63:0], r.hand_lo64);
            $display("seed=%h idx=%0d vec=%h", r.seed, bus_if.vec_idx, bus_if.vec);
        end
        tick();
        check("final_done", bus_if.done, 1'b1);
        check("final_busy", bus_if.busy, 1'b0);
        check("final_valid", bus_if.vec_valid, 1'b0);
    endtask

    initial begin
        logic [31:0]     s;
        logic [IN_W-1:0] ev;
        logic [IN_W-1:0] cap;
        int              c;
        bit              ok;

        rows[0] = '{32'h0000_0000, 1,   1'b1, 64'hD3DC167E_00003039};
        rows[1] = '{32'd2472402290, 100, 1'b0, 64'h0};
        rows[2] = '{32'hFFFF_FFFF,  3,   1'b0, 64'h0};
        rows[3] = '{32'h1234_5678,  0,   1'b0, 64'h0};

        rst                = 1'b1;
        bus_if.start       = 1'b0;
        bus_if.seed        = '0;
        bus_if.num_vectors = '0;
        bus_if.vec_ready   = 1'b0;
`ifdef LCG_STIM_PAUSE_EN
        pause              = 1'b0;
`endif
        repeat (3) tick();
        check("rst_vec", bus_if.vec, '0);
        check("rst_valid", bus_if.vec_valid, 1'b0);
        check("rst_idx", bus_if.vec_idx, '0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_done", bus_if.done, 1'b0);
        rst = 1'b0;
        tick();

        // Table of complete runs.
        for (int i = 0; i < 4; i++) run_stream(rows[i]);

        // Back-pressure: hold ready low for 10 cycles in VALID.
        s = 32'hCAFE_F00D;
        bus_if.vec_ready = 1'b0;
        do_start(s, 2);
        wait_valid(c, ok);
        check("bp_timeout", ok, 1'b1);
        m_vec(s, ev);
        check("bp_vec0", bus_if.vec, ev);
        cap = bus_if.vec;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", bus_if.vec_valid, 1'b1);
            check("bp_hold_vec", bus_if.vec, cap);
            check("bp_hold_idx", bus_if.vec_idx, 0);
        end
        bus_if.vec_ready = 1'b1;
        tick();
        check("bp_drop_valid", bus_if.vec_valid, 1'b0);
        wait_valid(c, ok);
        check("bp_latency", c, LAT - 1);
        m_vec(s, ev);
        check("bp_vec1", bus_if.vec, ev);
        check("bp_idx1", bus_if.vec_idx, 1);
        $display("backpressure idx=%0d vec=%h", bus_if.vec_idx, bus_if.vec);
        tick();
        check("bp_done", bus_if.done, 1'b1);

        // start during FILL must be ignored.
        s = 32'h0BAD_BEEF;
        do_start(s, 2);
        tick();
        bus_if.seed        = 32'h1111_1111;
        bus_if.num_vectors = '0;
        bus_if.start       = 1'b1;
        tick();
        bus_if.start       = 1'b0;
        check("ign_busy", bus_if.busy, 1'b1);
        check("ign_done", bus_if.done, 1'b0);
        for (int v = 0; v < 2; v++) begin
            wait_valid(c, ok);
            check("ign_timeout", ok, 1'b1);
            m_vec(s, ev);
            check("ign_vec", bus_if.vec, ev);
            check("ign_idx", bus_if.vec_idx, v);
            $display("ignored-start idx=%0d vec=%h", bus_if.vec_idx, bus_if.vec);
        end
        tick();
        check("ign_final_done", bus_if.done, 1'b1);

        // Reset in the middle of filling vector 3.
        s = 32'h5EED_0003;
        do_start(s, 10);
        for (int v = 0; v < 3; v++) begin
            wait_valid(c, ok);
            check("rstmid_timeout", ok, 1'b1);
            m_vec(s, ev);
            check("rstmid_vec", bus_if.vec, ev);
        end
        tick();
        tick();
        check("rstmid_idx3", bus_if.vec_idx, 3);
        check("rstmid_busy", bus_if.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_vec0", bus_if.vec, '0);
        check("rstmid_valid0", bus_if.vec_valid, 1'b0);
        check("rstmid_idx0", bus_if.vec_idx, '0);
        check("rstmid_busy0", bus_if.busy, 1'b0);
        check("rstmid_done0", bus_if.done, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rstmid_no_valid", bus_if.vec_valid, 1'b0);
        $display("reset mid-fill, restarting seed=%h", 32'h5EED_0003);
        run_stream('{32'h5EED_0003, 1, 1'b0, 64'h0});

`ifdef LCG_STIM_PAUSE_EN
        // Pause 4 cycles mid-FILL and 3 cycles in VALID.
        s = 32'h7777_0001;
        do_start(s, 2);
        tick();
        pause = 1'b1;
        repeat (4) tick();
        pause = 1'b0;
        wait_valid(c, ok);
        check("pause_fill_latency", c, LAT - 2);
        m_vec(s, ev);
        check("pause_vec0", bus_if.vec, ev);
        pause = 1'b1;
        #1;
        check("pause_valid_low", bus_if.vec_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_no_hs_idx", bus_if.vec_idx, 0);
            check("pause_valid_hidden", bus_if.vec_valid, 1'b0);
        end
        pause = 1'b0;
        wait_valid(c, ok);
        check("pause_latency1", c, LAT);
        m_vec(s, ev);
        check("pause_vec1", bus_if.vec, ev);
        check("pause_idx1", bus_if.vec_idx, 1);
        $display("pause idx=%0d vec=%h", bus_if.vec_idx, bus_if.vec);
        tick();
        check("pause_done", bus_if.done, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
